// File: rtl/mul_fifo_sched_if.sv
// Handshake bundle between the multiplier operand FIFO scheduler and its users.
// Producers and the consumer (master side) drive the request lines. The scheduler
// (slave side) returns the grants, storage strobes, write-data select, op-state,
// pointers, occupancy, full/empty flags and the error pulses.
//   wr_req0/wr_req1 : producer write requests (level, held until granted)
//   rd_req          : consumer read request
//   wr_gnt, rd_gnt  : combinational grants
//   we, re, wr_sel  : storage array controls
//   state           : registered op of the previous cycle
//   head, tail      : registered pointers
//   data_count      : registered occupancy
//   full, empty     : occupancy flags
//   wr_err, rd_err  : one-cycle rejection pulses
interface mul_fifo_sched_if #(
    parameter int AW = 3,
    parameter int CW = 4
);
    logic          wr_req0;
    logic          wr_req1;
    logic          rd_req;
    logic [1:0]    wr_gnt;
    logic          rd_gnt;
    logic          we;
    logic          re;
    logic          wr_sel;
    logic [2:0]    state;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] data_count;
    logic          full;
    logic          empty;
    logic          wr_err;
    logic          rd_err;

    modport master (
        output wr_req0, wr_req1, rd_req,
        input  wr_gnt, rd_gnt, we, re, wr_sel, state, head, tail,
               data_count, full, empty, wr_err, rd_err
    );

    modport slave (
        input  wr_req0, wr_req1, rd_req,
        output wr_gnt, rd_gnt, we, re, wr_sel, state, head, tail,
               data_count, full, empty, wr_err, rd_err
    );
endinterface

// File: rtl/mul_fifo_sched.sv
// Sequencer/arbiter for the multiplier operand FIFO.
// Each cycle at most one operation is picked among two write producers and one
// read consumer; the chosen op is registered as the op-state. The block owns the
// head/tail/data_count registers and drives the storage array strobes.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous, active-low reset
//   bus     : mul_fifo_sched_if slave modport (requests in; grants, strobes,
//             op-state, pointers, occupancy, flags and error pulses out)
module mul_fifo_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    mul_fifo_sched_if.slave bus
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5
    } op_e;

    op_e           state_q;
    op_e           op;
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          rr_last;     // port index of the last granted writer
    logic          rw_turn;     // 0: contested cycle goes to the write
    logic          wr_err_q;
    logic          rd_err_q;

    logic          w_any;
    logic          win;
    logic          full_c;
    logic          empty_c;
    logic          contested;

    always_comb begin
        full_c    = (count_q == CW'(DEPTH));
        empty_c   = (count_q == '0);
        w_any     = bus.wr_req0 | bus.wr_req1;
        // Both requesting: the port that did not win last time gets it.
        win       = (bus.wr_req0 & bus.wr_req1) ? ~rr_last : bus.wr_req1;
        // Only a genuine choice between read and write consumes the turn token;
        // full/empty resolve the conflict without touching it.
        contested = w_any & bus.rd_req & ~full_c & ~empty_c;

        op = NO_OP;
        if (!reset_n) begin
            op = NO_OP;
        end else if (w_any && !bus.rd_req) begin
            op = full_c ? WR_ERROR : WRITE;
        end else if (!w_any && bus.rd_req) begin
            op = empty_c ? RD_ERROR : READ;
        end else if (w_any && bus.rd_req) begin
            if (empty_c)      op = WRITE;
            else if (full_c)  op = READ;
            else              op = rw_turn ? READ : WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= INIT;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rr_last  <= 1'b1;
            rw_turn  <= 1'b0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= op;
            wr_err_q <= (op == WR_ERROR);
            rd_err_q <= (op == RD_ERROR);
            case (op)
                WRITE: begin
                    tail_q  <= tail_q + AW'(1);
                    count_q <= count_q + CW'(1);
                    rr_last <= win;
                end
                READ: begin
                    head_q  <= head_q + AW'(1);
                    count_q <= count_q - CW'(1);
                end
                default: ;
            endcase
            if (contested) rw_turn <= ~rw_turn;
        end
    end

    assign bus.we         = (op == WRITE);
    assign bus.re         = (op == READ);
    assign bus.rd_gnt     = (op == READ);
    assign bus.wr_gnt     = (op == WRITE) ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign bus.wr_sel     = win;
    assign bus.state      = state_q;
    assign bus.head       = head_q;
    assign bus.tail       = tail_q;
    assign bus.data_count = count_q;
    assign bus.full       = full_c;
    assign bus.empty      = empty_c;
    assign bus.wr_err     = wr_err_q;
    assign bus.rd_err     = rd_err_q;

endmodule

// File: tb/tb_mul_fifo_sched.sv
// Testbench for mul_fifo_sched: directed scenarios followed by randomized traffic,
// with expectations from a queue-based FIFO reference model fed to a scoreboard.
module tb_mul_fifo_sched;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic clk;
    logic reset_n;

    mul_fifo_sched_if #(.AW(AW), .CW(CW)) bus ();

    mul_fifo_sched #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gnt;
        int rg;
        int we;
        int re;
        int sel;
        int st;
        int hd;
        int tl;
        int cnt;
        int fl;
        int em;
        int werr;
        int rerr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: FIFO contents as a queue of writer ids, pointers as
    // free-running positions modulo DEPTH, arbitration as remembered winners.
    int fifo_m[$];
    int m_state;
    int m_head;
    int m_tail;
    int m_last;
    int m_turn;

    function automatic void model_reset();
        fifo_m.delete();
        m_state = 0;
        m_head  = 0;
        m_tail  = 0;
        m_last  = 1;
        m_turn  = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        n_cmp++;
        if (act !== 32'(expv)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle of stimulus; the expectation for this cycle goes to the scoreboard.
    task automatic cyc(input bit rn, input bit w0, input bit w1, input bit rd);
        exp_t e;
        int   op;
        int   winner;
        int   n;
        bit   w;
        @(negedge clk);
        reset_n     = rn;
        bus.wr_req0 = w0;
        bus.wr_req1 = w1;
        bus.rd_req  = rd;

        n = fifo_m.size();
        w = w0 | w1;
        winner = (w0 && w1) ? (m_last == 0 ? 1 : 0) : (w1 ? 1 : 0);
        if (!rn)                op = 1;
        else if (!w && !rd)     op = 1;
        else if (w && !rd)      op = (n == DEPTH) ? 3 : 2;
        else if (!w && rd)      op = (n == 0) ? 5 : 4;
        else if (n == 0)        op = 2;
        else if (n == DEPTH)    op = 4;
        else begin
            op = m_turn ? 4 : 2;
            m_turn = 1 - m_turn;
        end

        e.gnt  = (op == 2) ? (1 << winner) : 0;
        e.we   = (op == 2);
        e.re   = (op == 4);
        e.rg   = (op == 4);
        e.sel  = winner;
        e.st   = m_state;
        e.hd   = m_head;
        e.tl   = m_tail;
        e.cnt  = n;
        e.fl   = (n == DEPTH);
        e.em   = (n == 0);
        e.werr = (m_state == 3);
        e.rerr = (m_state == 5);
        exp_q.push_back(e);

        if (!rn) begin
            model_reset();
        end else begin
            m_state = op;
            if (op == 2) begin
                fifo_m.push_back(winner);
                m_tail = (m_tail + 1) % DEPTH;
                m_last = winner;
            end else if (op == 4) begin
                void'(fifo_m.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
        end
    endtask

    // Monitor: samples the DUT mid-cycle and retires one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_gnt",     32'(bus.wr_gnt),     e.gnt);
                chk("rd_gnt",     32'(bus.rd_gnt),     e.rg);
                chk("we",         32'(bus.we),         e.we);
                chk("re",         32'(bus.re),         e.re);
                if (e.we != 0) chk("wr_sel", 32'(bus.wr_sel), e.sel);
                chk("state",      32'(bus.state),      e.st);
                chk("head",       32'(bus.head),       e.hd);
                chk("tail",       32'(bus.tail),       e.tl);
                chk("data_count", 32'(bus.data_count), e.cnt);
                chk("full",       32'(bus.full),       e.fl);
                chk("empty",      32'(bus.empty),      e.em);
                chk("wr_err",     32'(bus.wr_err),     e.werr);
                chk("rd_err",     32'(bus.rd_err),     e.rerr);
            end
        end
    end

    initial begin
        int wp;
        int rp;
        reset_n     = 1'b0;
        bus.wr_req0 = 1'b0;
        bus.wr_req1 = 1'b0;
        bus.rd_req  = 1'b0;
        model_reset();

        // Reset state.
        cyc(0, 0, 0, 0);
        // Fill to full from port 0, tail wraps, then one rejected write.
        for (int i = 0; i < 9; i++) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        // Full with write+read held: forced read, then contested write.
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(1, 0, 0, 0);
        // Round-robin between both producers.
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
        // Read from empty, then write+read on empty.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        // Build count to 3, reset mid-burst with a pending request.
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);

        // Randomized traffic in phases of varying write/read pressure.
        for (int ph = 0; ph < 8; ph++) begin
            wp = $urandom_range(20, 90);
            rp = $urandom_range(10, 80);
            for (int i = 0; i < 60; i++) begin
                cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                    ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0);
            end
        end

        // Let the monitor retire the last expectation, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
